// File: rtl/atm_cash_dispenser.sv
// ATM cash dispenser: captures a request on the success rising edge, plans a greedy
// note breakdown against the vault, then feeds notes one at a time over valid/ack.
module atm_cash_dispenser #(
  parameter int unsigned INIT_N1000 = 2,
  parameter int unsigned INIT_N500  = 4,
  parameter int unsigned INIT_N100  = 10,
  parameter int unsigned INIT_N50   = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        success,
  input  logic [13:0] cash_amt,
  input  logic        cancel,
  input  logic        note_ack,
  output logic        note_valid,
  output logic [1:0]  note_denom,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [1:0]  err_code,
  output logic [13:0] dispensed_total,
  output logic [7:0]  inv_1000,
  output logic [7:0]  inv_500,
  output logic [7:0]  inv_100,
  output logic [7:0]  inv_50
);

  localparam int unsigned AMT_W     = 14;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned NUM_DENOM = 4;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_BAD   = 2'd1;
  localparam logic [1:0] ERR_SHORT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PLAN,
    S_DISPENSE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t state_q, state_d;

  logic                                success_prev_q;
  logic [AMT_W-1:0]                    remaining_q, remaining_d;
  logic [AMT_W-1:0]                    total_q, total_d;
  logic [NUM_DENOM-1:0][CNT_W-1:0]     inv_q, inv_d;
  logic [NUM_DENOM-1:0][CNT_W-1:0]     plan_q, plan_d;
  logic [NUM_DENOM-1:0][CNT_W-1:0]     inv_init;
  logic                                note_valid_q, note_valid_d;
  logic [1:0]                          denom_q, denom_d;
  logic                                busy_q, busy_d;
  logic                                done_q, done_d;
  logic                                error_q, error_d;
  logic [1:0]                          err_code_q, err_code_d;

  logic                                req_edge_c;
  logic                                amt_ok_c;
  logic                                ack_fire_c;
  logic                                plan_found_c;
  logic [1:0]                          plan_sel_c;
  logic [NUM_DENOM-1:0][CNT_W-1:0]     plan_after_c;
  logic                                disp_found_c;
  logic [1:0]                          disp_sel_c;

  // Denomination code to face value.
  function automatic logic [AMT_W-1:0] denom_value(input logic [1:0] code);
    logic [AMT_W-1:0] v;
    case (code)
      2'd0:    v = AMT_W'(50);
      2'd1:    v = AMT_W'(100);
      2'd2:    v = AMT_W'(500);
      default: v = AMT_W'(1000);
    endcase
    return v;
  endfunction

  assign inv_init = {CNT_W'(INIT_N1000), CNT_W'(INIT_N500),
                     CNT_W'(INIT_N100),  CNT_W'(INIT_N50)};

  assign req_edge_c = success & ~success_prev_q;
  assign amt_ok_c   = (cash_amt != '0) && ((cash_amt % AMT_W'(50)) == '0);
  assign ack_fire_c = note_valid_q & note_ack;

  // Greedy pick: largest denomination that fits the remainder and still has unplanned stock.
  always_comb begin
    logic [1:0] idx;
    plan_found_c = 1'b0;
    plan_sel_c   = 2'd0;
    idx          = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = 2'(i);
      if (!plan_found_c && (inv_q[idx] > plan_q[idx]) &&
          (denom_value(idx) <= remaining_q)) begin
        plan_found_c = 1'b1;
        plan_sel_c   = idx;
      end
    end
  end

  // Plan counts after this cycle's ack, and the next note to present from them.
  always_comb begin
    logic [1:0] idx;
    plan_after_c = plan_q;
    if (ack_fire_c) begin
      plan_after_c[denom_q] = plan_q[denom_q] - CNT_W'(1);
    end
    disp_found_c = 1'b0;
    disp_sel_c   = 2'd0;
    idx          = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = 2'(i);
      if (!disp_found_c && (plan_after_c[idx] != '0)) begin
        disp_found_c = 1'b1;
        disp_sel_c   = idx;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    total_d      = total_q;
    inv_d        = inv_q;
    plan_d       = plan_q;
    err_code_d   = err_code_q;
    note_valid_d = 1'b0;
    denom_d      = denom_q;

    case (state_q)
      S_IDLE: begin
        if (req_edge_c && !cancel) begin
          if (!amt_ok_c) begin
            state_d    = S_ERROR;
            err_code_d = ERR_BAD;
          end else begin
            state_d     = S_PLAN;
            remaining_d = cash_amt;
            plan_d      = '0;
            total_d     = '0;
            err_code_d  = ERR_NONE;
          end
        end
      end
      S_PLAN: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else if (plan_found_c) begin
          plan_d[plan_sel_c] = plan_q[plan_sel_c] + CNT_W'(1);
          remaining_d        = remaining_q - denom_value(plan_sel_c);
          if (remaining_q == denom_value(plan_sel_c)) begin
            state_d = S_DISPENSE;
          end
        end else begin
          state_d    = S_ERROR;
          err_code_d = ERR_SHORT;
        end
      end
      S_DISPENSE: begin
        if (ack_fire_c) begin
          plan_d           = plan_after_c;
          inv_d[denom_q]   = inv_q[denom_q] - CNT_W'(1);
          total_d          = total_q + denom_value(denom_q);
        end
        if (disp_found_c) begin
          note_valid_d = 1'b1;
          denom_d      = disp_sel_c;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d == S_PLAN) || (state_d == S_DISPENSE);
    done_d  = (state_d == S_DONE);
    error_d = (state_d == S_ERROR);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      success_prev_q <= 1'b0;
      remaining_q    <= '0;
      total_q        <= '0;
      inv_q          <= inv_init;
      plan_q         <= '0;
      note_valid_q   <= 1'b0;
      denom_q        <= 2'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      err_code_q     <= ERR_NONE;
    end else begin
      state_q        <= state_d;
      success_prev_q <= success;
      remaining_q    <= remaining_d;
      total_q        <= total_d;
      inv_q          <= inv_d;
      plan_q         <= plan_d;
      note_valid_q   <= note_valid_d;
      denom_q        <= denom_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      err_code_q     <= err_code_d;
    end
  end

  assign note_valid      = note_valid_q;
  assign note_denom      = denom_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;
  assign err_code        = err_code_q;
  assign dispensed_total = total_q;
  assign inv_1000        = inv_q[3];
  assign inv_500         = inv_q[2];
  assign inv_100         = inv_q[1];
  assign inv_50          = inv_q[0];

endmodule

// File: tb/tb_atm_cash_dispenser.sv
// Directed bench for atm_cash_dispenser: note sequences, rejects, stalls, retrigger and abort cases.
module tb_atm_cash_dispenser;

  logic        clk = 1'b0;
  logic        rst, success, cancel, note_ack;
  logic [13:0] cash_amt;
  logic        note_valid, busy, done, error;
  logic [1:0]  note_denom, err_code;
  logic [13:0] dispensed_total;
  logic [7:0]  inv_1000, inv_500, inv_100, inv_50;

  int checks = 0;
  int errors = 0;

  logic [1:0] notes[$];
  int         done_cnt, err_cnt, valid_cyc, last_cyc;
  bit         timed_out;

  atm_cash_dispenser dut (
    .clk(clk), .rst(rst), .success(success), .cash_amt(cash_amt), .cancel(cancel),
    .note_ack(note_ack), .note_valid(note_valid), .note_denom(note_denom), .busy(busy),
    .done(done), .error(error), .err_code(err_code), .dispensed_total(dispensed_total),
    .inv_1000(inv_1000), .inv_500(inv_500), .inv_100(inv_100), .inv_50(inv_50)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Raise success, then watch until done/error; records acked note codes in order.
  task automatic do_request(input logic [13:0] amt, input bit hold, input int max_cyc);
    bit fin;
    notes.delete();
    done_cnt = 0; err_cnt = 0; valid_cyc = -1; last_cyc = -1; timed_out = 0; fin = 0;
    cash_amt = amt;
    success  = 1'b1;
    for (int c = 1; c <= max_cyc && !fin; c++) begin
      tick();
      if (!hold) success = 1'b0;
      if (note_valid && valid_cyc < 0) valid_cyc = c;
      if (note_valid && note_ack) notes.push_back(note_denom);
      if (done) done_cnt++;
      if (error) err_cnt++;
      if (done || error) begin
        fin = 1;
        last_cyc = c;
      end
    end
    if (!fin) timed_out = 1;
  endtask

  function automatic logic [15:0] pack_notes();
    logic [15:0] s;
    s = '0;
    foreach (notes[i]) s = {s[13:0], notes[i]};
    return s;
  endfunction

  task automatic test_reset();
    checks++;
    if ({note_valid, note_denom, busy, done, error, err_code, dispensed_total} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs got v=%b d=%0d b=%b dn=%b e=%b ec=%0d t=%0d exp all 0",
               note_valid, note_denom, busy, done, error, err_code, dispensed_total);
    end
    checks++;
    if ({inv_1000, inv_500, inv_100, inv_50} !== {8'd2, 8'd4, 8'd10, 8'd10}) begin
      errors++;
      $display("FAIL reset_inv got %0d,%0d,%0d,%0d exp 2,4,10,10", inv_1000, inv_500, inv_100, inv_50);
    end
  endtask

  task automatic test_basic();
    note_ack = 1'b1;
    do_request(14'd1650, 1'b0, 100);
    checks++;
    if (timed_out) begin errors++; $display("FAIL basic_timeout got no done exp done"); end
    checks++;
    if (notes.size() != 4 || pack_notes() !== 16'h00E4) begin
      errors++;
      $display("FAIL basic_seq got n=%0d seq=%h exp n=4 seq=00e4", notes.size(), pack_notes());
    end
    checks++;
    if (valid_cyc != 6) begin errors++; $display("FAIL basic_latency got %0d exp 6", valid_cyc); end
    checks++;
    if (last_cyc != 10) begin errors++; $display("FAIL basic_done_cycle got %0d exp 10", last_cyc); end
    checks++;
    if (dispensed_total !== 14'd1650) begin
      errors++; $display("FAIL basic_total got %0d exp 1650", dispensed_total);
    end
    checks++;
    if ({inv_1000, inv_500, inv_100, inv_50} !== {8'd1, 8'd3, 8'd9, 8'd9}) begin
      errors++;
      $display("FAIL basic_inv got %0d,%0d,%0d,%0d exp 1,3,9,9", inv_1000, inv_500, inv_100, inv_50);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || err_code !== 2'd0) begin
      errors++; $display("FAIL basic_after got done=%b busy=%b ec=%0d exp 0,0,0", done, busy, err_code);
    end
  endtask

  task automatic test_bad_amount();
    bit bad;
    do_request(14'd1230, 1'b0, 20);
    checks++;
    if (err_cnt != 1 || err_code !== 2'd1 || valid_cyc != -1) begin
      errors++;
      $display("FAIL bad1230 got err=%0d ec=%0d vcyc=%0d exp 1,1,-1", err_cnt, err_code, valid_cyc);
    end
    checks++;
    if ({inv_1000, inv_500, inv_100, inv_50} !== {8'd1, 8'd3, 8'd9, 8'd9} || dispensed_total !== 14'd1650) begin
      errors++;
      $display("FAIL bad1230_state got inv %0d,%0d,%0d,%0d t=%0d exp 1,3,9,9 t=1650",
               inv_1000, inv_500, inv_100, inv_50, dispensed_total);
    end
    tick();
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL bad_pulse_width got %b exp 0", error); end
    do_request(14'd0, 1'b0, 20);
    checks++;
    if (err_cnt != 1 || err_code !== 2'd1 || valid_cyc != -1) begin
      errors++;
      $display("FAIL bad_zero got err=%0d ec=%0d vcyc=%0d exp 1,1,-1", err_cnt, err_code, valid_cyc);
    end
    // Cancel on the request edge wins; success held high afterwards must not retrigger.
    cash_amt = 14'd50;
    success  = 1'b1;
    cancel   = 1'b1;
    tick();
    cancel = 1'b0;
    bad = (busy || error || note_valid);
    for (int c = 0; c < 4; c++) begin
      tick();
      if (busy || error || note_valid || done) bad = 1;
    end
    success = 1'b0;
    checks++;
    if (bad || err_code !== 2'd1) begin
      errors++; $display("FAIL cancel_wins got activity=%b ec=%0d exp 0,1", bad, err_code);
    end
  endtask

  task automatic test_insufficient();
    apply_reset();
    note_ack = 1'b1;
    do_request(14'd3000, 1'b0, 100);
    checks++;
    if (notes.size() != 4 || pack_notes() !== 16'h00FA || done_cnt != 1) begin
      errors++;
      $display("FAIL first3000_seq got n=%0d seq=%h done=%0d exp 4 00fa 1", notes.size(), pack_notes(), done_cnt);
    end
    checks++;
    if ({inv_1000, inv_500, inv_100, inv_50} !== {8'd0, 8'd2, 8'd10, 8'd10} || dispensed_total !== 14'd3000) begin
      errors++;
      $display("FAIL first3000_inv got %0d,%0d,%0d,%0d t=%0d exp 0,2,10,10 t=3000",
               inv_1000, inv_500, inv_100, inv_50, dispensed_total);
    end
    tick();
    do_request(14'd3000, 1'b0, 100);
    checks++;
    if (err_cnt != 1 || err_code !== 2'd2 || valid_cyc != -1 || last_cyc != 24) begin
      errors++;
      $display("FAIL second3000 got err=%0d ec=%0d vcyc=%0d cyc=%0d exp 1,2,-1,24",
               err_cnt, err_code, valid_cyc, last_cyc);
    end
    checks++;
    if ({inv_1000, inv_500, inv_100, inv_50} !== {8'd0, 8'd2, 8'd10, 8'd10} || dispensed_total !== 14'd0) begin
      errors++;
      $display("FAIL second3000_inv got %0d,%0d,%0d,%0d t=%0d exp 0,2,10,10 t=0",
               inv_1000, inv_500, inv_100, inv_50, dispensed_total);
    end
    for (int c = 0; c < 3; c++) tick();
    checks++;
    if (err_code !== 2'd2) begin errors++; $display("FAIL err_code_hold got %0d exp 2", err_code); end
  endtask

  task automatic test_ack_stall();
    bit stable, seen;
    apply_reset();
    note_ack = 1'b0;
    cash_amt = 14'd100;
    success  = 1'b1;
    seen     = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      success = 1'b0;
      if (note_valid) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_valid got no note_valid exp note_valid"); end
    stable = 1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (!(note_valid === 1'b1 && note_denom === 2'd1 && inv_100 === 8'd10 && done === 1'b0)) stable = 0;
    end
    checks++;
    if (!stable) begin
      errors++; $display("FAIL stall_hold got v=%b d=%0d inv100=%0d exp 1,1,10", note_valid, note_denom, inv_100);
    end
    note_ack = 1'b1;
    tick();
    note_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || note_valid !== 1'b0 || inv_100 !== 8'd9 || dispensed_total !== 14'd100) begin
      errors++;
      $display("FAIL stall_ack got done=%b v=%b inv100=%0d t=%0d exp 1,0,9,100",
               done, note_valid, inv_100, dispensed_total);
    end
    tick();
  endtask

  task automatic test_success_hold();
    bit bad;
    note_ack = 1'b1;
    do_request(14'd50, 1'b1, 50);
    checks++;
    if (done_cnt != 1 || notes.size() != 1 || pack_notes() !== 16'h0000 || inv_50 !== 8'd9) begin
      errors++;
      $display("FAIL hold_first got done=%0d n=%0d inv50=%0d exp 1,1,9", done_cnt, notes.size(), inv_50);
    end
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (note_valid || busy || done || error) bad = 1;
    end
    success = 1'b0;
    tick();
    checks++;
    if (bad || inv_50 !== 8'd9) begin
      errors++; $display("FAIL hold_retrigger got activity=%b inv50=%0d exp 0,9", bad, inv_50);
    end
  endtask

  task automatic test_edge_busy();
    int acks, dones;
    note_ack = 1'b1;
    cash_amt = 14'd1000;
    success  = 1'b1;
    tick();
    success = 1'b0;
    tick();
    success  = 1'b1;
    cash_amt = 14'd50;
    acks = 0; dones = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (note_valid && note_ack) acks++;
      if (done) dones++;
    end
    success = 1'b0;
    checks++;
    if (acks != 1 || dones != 1 || inv_1000 !== 8'd1 || inv_50 !== 8'd9 || dispensed_total !== 14'd1000) begin
      errors++;
      $display("FAIL edge_busy got acks=%0d dones=%0d inv1000=%0d inv50=%0d t=%0d exp 1,1,1,9,1000",
               acks, dones, inv_1000, inv_50, dispensed_total);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit seen;
    apply_reset();
    note_ack = 1'b1;
    cash_amt = 14'd2000;
    success  = 1'b1;
    seen     = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      success = 1'b0;
      if (note_valid) seen = 1;
    end
    tick();
    checks++;
    if (!seen || inv_1000 !== 8'd1 || note_valid !== 1'b1) begin
      errors++; $display("FAIL mid_first_ack got seen=%b inv1000=%0d v=%b exp 1,1,1", seen, inv_1000, note_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({note_valid, note_denom, busy, done, error, err_code, dispensed_total} !== 22'd0 ||
        {inv_1000, inv_500, inv_100, inv_50} !== {8'd2, 8'd4, 8'd10, 8'd10}) begin
      errors++;
      $display("FAIL mid_reset got v=%b b=%b t=%0d inv %0d,%0d,%0d,%0d exp 0,0,0 inv 2,4,10,10",
               note_valid, busy, dispensed_total, inv_1000, inv_500, inv_100, inv_50);
    end
    tick();
    tick();
    checks++;
    if (note_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_idle got v=%b b=%b exp 0,0", note_valid, busy);
    end
  endtask

  task automatic test_cancel();
    bit bad, seen;
    note_ack = 1'b1;
    cash_amt = 14'd1650;
    success  = 1'b1;
    tick();
    success = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL cancel_plan_busy got %b exp 1", busy); end
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    bad = busy;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (note_valid || done || error || busy) bad = 1;
    end
    checks++;
    if (bad || {inv_1000, inv_500, inv_100, inv_50} !== {8'd2, 8'd4, 8'd10, 8'd10}) begin
      errors++;
      $display("FAIL cancel_plan got activity=%b inv %0d,%0d,%0d,%0d exp 0 inv 2,4,10,10",
               bad, inv_1000, inv_500, inv_100, inv_50);
    end
    // Cancel during DISPENSE has no effect.
    note_ack = 1'b0;
    cash_amt = 14'd100;
    success  = 1'b1;
    seen     = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      success = 1'b0;
      if (note_valid) seen = 1;
    end
    cancel = 1'b1;
    tick();
    tick();
    cancel = 1'b0;
    checks++;
    if (!seen || note_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL cancel_dispense got v=%b b=%b exp 1,1", note_valid, busy);
    end
    note_ack = 1'b1;
    tick();
    note_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || inv_100 !== 8'd9) begin
      errors++; $display("FAIL cancel_dispense_done got done=%b inv100=%0d exp 1,9", done, inv_100);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; success = 1'b0; cancel = 1'b0; note_ack = 1'b0; cash_amt = '0;
    apply_reset();
    test_reset();
    test_basic();
    test_bad_amount();
    test_insufficient();
    test_ack_stall();
    test_success_hold();
    test_edge_busy();
    test_reset_mid();
    test_cancel();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/atm_cash_dispenser.md
Name: atm_cash_dispenser

Overview:
- Downstream stage of the ATM transaction FSM. On the rising edge of the FSM's `success` output, it captures `cash_out` as the requested amount.
- It plans a greedy note breakdown against the vault inventory, then drives a note-feed mechanism one note at a time over a valid/ack handshake.
- It keeps per-denomination vault counts, reports the total dispensed, and flags invalid or unserviceable requests without dispensing anything.

Parameters:
- INIT_N1000, 2, notes of 1000 loaded into the vault on reset
- INIT_N500, 4, notes of 500 loaded on reset
- INIT_N100, 10, notes of 100 loaded on reset
- INIT_N50, 10, notes of 50 loaded on reset

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- success  in  1  dispense request level from the transaction FSM
- cash_amt  in  14  requested amount; sampled only on the `success` rising edge
- cancel  in  1  abort request; honoured in IDLE/PLAN only
- note_ack  in  1  feeder accepted the presented note
- note_valid  out  1  a note is presented to the feeder
- note_denom  out  2  denomination code: 0=50, 1=100, 2=500, 3=1000
- busy  out  1  high in PLAN and DISPENSE
- done  out  1  one-cycle pulse when the last note is acked
- error  out  1  one-cycle pulse when a request is rejected
- err_code  out  2  0=none, 1=bad amount, 2=insufficient notes; held until the next accepted request
- dispensed_total  out  14  sum of acked note values for the current/last request
- inv_1000, inv_500, inv_100, inv_50  out  8 each  current vault counts

Behaviour:
- Reset (`rst`=1 at a clk edge):
  - state=IDLE; note_valid, note_denom, busy, done, error, err_code, dispensed_total all 0.
  - inv_* = INIT_*; plan counters 0; success_prev=0.
- Request detect: `success`=1 and `success_prev`=0, sampled in IDLE only. Edges in any other state are ignored; `success` held high never retriggers.
- States: IDLE, PLAN, DISPENSE, DONE, ERROR.
- IDLE, on an edge:
  - `cancel`=1 the same cycle: stay IDLE (cancel wins).
  - `cash_amt`==0 or not a multiple of 50: go to ERROR, err_code=1.
  - Otherwise: remaining=`cash_amt`, clear plan counts, dispensed_total=0, err_code=0, go to PLAN.
- PLAN, one note per cycle:
  - Select the largest denomination d with d<=remaining and (inventory − planned count for d)>0.
  - Increment the plan count for d; remaining −= d.
  - If remaining reaches 0 on this edge, go to DISPENSE.
  - If no denomination qualifies, go to ERROR with err_code=2. No inventory changes.
  - `cancel` in PLAN: return to IDLE, no pulse, no inventory change.
  - The breakdown is greedy; no backtracking search.
- Latency: for N planned notes, note_valid first rises at the N+1th clk edge after the request-detect edge.
- DISPENSE:
  - Notes are issued largest denomination first.
  - note_valid=1, with note_denom = the largest denomination whose plan count >0.
  - note_denom is stable while note_valid=1 and note_ack=0.
  - On a cycle with note_valid & note_ack: decrement that plan count and the matching inv_* by 1; dispensed_total += value.
  - note_valid may stay high back-to-back for the next note.
  - After the final ack: note_valid=0, go to DONE.
  - `cancel` is ignored in DISPENSE.
- DONE: done=1 for exactly one cycle, then IDLE.
- ERROR: error=1 for exactly one cycle, then IDLE.
- Ack timing: note_ack while note_valid=0 is ignored.
- Arithmetic:
  - remaining and dispensed_total are 14-bit unsigned; underflow is impossible by the selection rule.
  - inv_* never wrap, because inventory is only decremented for planned notes.
- Reset mid-operation restores the full reset state, including inventory reload. Partially dispensed notes are not recorded.

Test Plan:
- Defaults, `success` edge with cash_amt=1650, note_ack tied 1 -> note_denom sequence 3,2,1,0 on consecutive cycles; done pulse; dispensed_total=1650; inv = 1,3,9,9.
- cash_amt=1230 -> error pulse, err_code=1, note_valid never asserted, inventories unchanged.
- cash_amt=3000 twice from reset:
  - First -> notes 3,3,2,2; inv = 0,2,10,10.
  - Second -> plan 500,500, 100×10, 50×10 leaves 500 -> err_code=2, inventories unchanged.
- cash_amt=100 with note_ack held 0 for 5 cycles -> note_valid=1 and note_denom=1 stable, inv_100 unchanged; ack -> inv_100=9, done pulse.
- Hold `success` high 10 cycles past done -> exactly one dispense. Edge during busy -> ignored.
- cash_amt=2000, rst pulsed after the first ack -> all outputs at reset values, inv_1000=2. cancel in PLAN -> IDLE, no pulse, no note_valid.
